// File: rtl/pipelined_addsub.sv
// Pipelined add/sub with N/Z/V/C flags; one carry segment per stage, operands registered on accept.
// Latency STAGES+... : accepted at edge k, out_valid after edge k+STAGES; whole pipe stalls when out_valid & !out_ready.
module pipelined_addsub #(
  parameter int BITS = 16,
  parameter int SEG  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic            cin,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] result,
  output logic            n,
  output logic            z,
  output logic            v,
  output logic            c
);

  localparam int STAGES = BITS / SEG;

  logic                advance;
  logic [BITS-1:0]     bx;
  logic                cin0;

  // Index 0 is the operand register; indices 1..STAGES each resolve one segment.
  logic [STAGES:0]     vld;
  logic [STAGES:0]     cy;
  logic [STAGES:0]     zr;
  logic [STAGES:1]     cm;
  logic [BITS-1:0]     opa [0:STAGES-1];
  logic [BITS-1:0]     opb [0:STAGES-1];
  logic [BITS-1:0]     sum [0:STAGES];

  logic [BITS-1:0]     sum_nxt [1:STAGES];
  logic [STAGES:1]     cy_nxt;
  logic [STAGES:1]     cm_nxt;
  logic [STAGES:1]     zr_nxt;

  assign out_valid = vld[STAGES];
  assign advance   = !out_valid | out_ready;
  assign in_ready  = advance;

  // Subtraction is a + ~b + 1 so that b = most-negative yields correct C and V.
  always_comb begin
    bx   = op[0] ? ~b : b;
    cin0 = op[1] ? cin : op[0];
  end

  always_comb begin
    logic [SEG:0] seg;
    seg = '0;
    for (int j = 1; j <= STAGES; j++) begin
      seg = {1'b0, opa[j-1][(j-1)*SEG +: SEG]}
          + {1'b0, opb[j-1][(j-1)*SEG +: SEG]}
          + {{SEG{1'b0}}, cy[j-1]};
      sum_nxt[j]                   = sum[j-1];
      sum_nxt[j][(j-1)*SEG +: SEG] = seg[SEG-1:0];
      cy_nxt[j]                    = seg[SEG];
      // Carry into the segment MSB recovered from the MSB sum bit and its inputs.
      cm_nxt[j] = opa[j-1][j*SEG-1] ^ opb[j-1][j*SEG-1] ^ seg[SEG-1];
      zr_nxt[j] = zr[j-1] & ~|seg[SEG-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      cy  <= '0;
      zr  <= '0;
      cm  <= '0;
      for (int j = 0; j < STAGES; j++) begin
        opa[j] <= '0;
        opb[j] <= '0;
      end
      for (int j = 0; j <= STAGES; j++) begin
        sum[j] <= '0;
      end
    end else if (advance) begin
      vld[0] <= in_valid;
      opa[0] <= a;
      opb[0] <= bx;
      cy[0]  <= cin0;
      sum[0] <= '0;
      zr[0]  <= 1'b1;
      for (int j = 1; j <= STAGES; j++) begin
        vld[j] <= vld[j-1];
        sum[j] <= sum_nxt[j];
        cy[j]  <= cy_nxt[j];
        cm[j]  <= cm_nxt[j];
        zr[j]  <= zr_nxt[j];
      end
      for (int j = 1; j < STAGES; j++) begin
        opa[j] <= opa[j-1];
        opb[j] <= opb[j-1];
      end
    end
  end

  assign result = sum[STAGES];
  assign n      = sum[STAGES][BITS-1];
  assign z      = zr[STAGES];
  assign c      = cy[STAGES];
  assign v      = cm[STAGES] ^ cy[STAGES];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: arithmetic reference model plus directed literal vectors.
module tb_pipelined_addsub;

  localparam int BITS = 16;
  localparam int SEG  = 4;
  localparam int LAT  = BITS / SEG;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic            cin;
  logic [BITS-1:0] a;
  logic [BITS-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] result;
  logic            n, z, v, c;

  int checks   = 0;
  int fails    = 0;
  int accepted = 0;
  int emitted  = 0;

  logic [19:0] expq[$];
  logic [19:0] got;
  logic [19:0] held_val;
  logic        held = 1'b0;

  pipelined_addsub #(.BITS(BITS), .SEG(SEG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .cin(cin), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .n(n), .z(z), .v(v), .c(c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic; packs {result, n, z, v, c}.
  function automatic logic [19:0] model(input logic [1:0] fop, input logic fcin,
                                        input logic [15:0] fa, input logic [15:0] fb);
    int ua, ub, sa, sb, ci, ures, sres;
    logic [15:0] r;
    logic fc, fv;
    ua = fa;
    ub = fb;
    sa = $signed(fa);
    sb = $signed(fb);
    ci = (fop == 2'b00) ? 0 : (fop == 2'b01) ? 1 : int'(fcin);
    if (!fop[0]) begin
      ures = ua + ub + ci;
      sres = sa + sb + ci;
      fc   = (ures > 65535);
    end else begin
      ures = ua - ub - 1 + ci;
      sres = sa - sb - 1 + ci;
      fc   = (ures >= 0);
    end
    r  = ures[15:0];
    fv = (sres > 32767) || (sres < -32768);
    return {r, r[15], (r == 16'h0000), fv, fc};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      held     = 1'b0;
      accepted = emitted;
    end else begin
      got = {result, n, z, v, c};
      if (held) chk("stall_stable", {12'b0, got}, {12'b0, held_val});
      if (out_valid) begin
        if (expq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL spurious_out got=%h expected=no result", got);
        end else begin
          chk("model", {12'b0, got}, {12'b0, expq[0]});
          if (out_ready) begin
            void'(expq.pop_front());
            emitted++;
          end
        end
      end
      held     = out_valid && !out_ready;
      held_val = got;
      if (in_valid && in_ready) begin
        expq.push_back(model(op, cin, a, b));
        accepted++;
      end
    end
  end

  task automatic rnd_op();
    op  = 2'($urandom_range(0, 3));
    cin = 1'($urandom_range(0, 1));
    a   = 16'($urandom);
    b   = 16'($urandom);
  endtask

  // Called #1 after a rising edge; single op, checks latency and literal result.
  task automatic send_one(input string name, input logic [1:0] sop, input logic scin,
                          input logic [15:0] sa, input logic [15:0] sb, input logic [19:0] exp);
    int lat;
    op = sop; cin = scin; a = sa; b = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk({name, "_lat"}, lat, LAT);
    chk({name, "_val"}, {12'b0, result, n, z, v, c}, {12'b0, exp});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = 2'b00; cin = 1'b0; a = '0; b = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result_flags", {result, n, z, v, c}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    send_one("add_7fff_1",  2'b00, 1'b0, 16'h7FFF, 16'h0001, {16'h8000, 4'b1010});
    send_one("add_ffff_1",  2'b00, 1'b1, 16'hFFFF, 16'h0001, {16'h0000, 4'b0101});
    send_one("sub_5_5",     2'b01, 1'b0, 16'h0005, 16'h0005, {16'h0000, 4'b0101});
    send_one("sub_0_1",     2'b01, 1'b0, 16'h0000, 16'h0001, {16'hFFFF, 4'b1000});
    send_one("sub_8000_1",  2'b01, 1'b0, 16'h8000, 16'h0001, {16'h7FFF, 4'b0011});
    send_one("sub_0_8000",  2'b01, 1'b0, 16'h0000, 16'h8000, {16'h8000, 4'b1010});
    send_one("adc_ffff_0",  2'b10, 1'b1, 16'hFFFF, 16'h0000, {16'h0000, 4'b0101});
    send_one("sbc_10_1",    2'b11, 1'b0, 16'h0010, 16'h0001, {16'h000E, 4'b0001});

    // Eight back-to-back ops accepted at edges 1..8 -> valid after edges 5..12.
    rnd_op(); in_valid = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_valid_e%0d", e), out_valid, (e >= 5 && e <= 12));
      if (e < 8) rnd_op();
      else in_valid = 1'b0;
    end

    // Fill, then stall three cycles with the next op held upstream.
    rnd_op(); in_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      rnd_op();
    end
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Bubbles: alternate in_valid, with a short downstream stall in the middle.
    for (int k = 0; k < 12; k++) begin
      rnd_op();
      in_valid  = (k % 2 == 0);
      out_ready = (k != 5);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_count", emitted, accepted);
    chk("drain_queue_empty", expq.size(), 0);

    // Three ops in flight, reset before any emerges.
    rnd_op(); in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k < 3) rnd_op();
      else in_valid = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result_flags", {result, n, z, v, c}, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("postrst_no_output", out_valid, 0);
    send_one("postrst_add", 2'b00, 1'b0, 16'h1234, 16'h0001, {16'h1235, 4'b0000});
    chk("final_queue_empty", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
